csi2_raw10_unpacker: RTL and testbench



---
 rtl/csi2_pkg.sv | 10 +
 rtl/raw10_group_decode.sv | 14 +
 rtl/csi2_raw10_unpacker.sv | 94 +++++++++
 tb/tb_csi2_raw10_unpacker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions for the pixel-domain unpackers.
package csi2_pkg;

  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;

  localparam int unsigned Raw10GroupBytes = 5;

endpackage

// File: rtl/raw10_group_decode.sv
// Combinational RAW10 unpack: five packed bytes into four 10-bit pixels.
module raw10_group_decode (
  input  logic [4:0][7:0] bytes_i,
  output logic [3:0][9:0] pixel_o
);

  // The fifth byte carries the two LSBs of each pixel, pixel 0 in bits [1:0].
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pixel_o[i] = {bytes_i[i], bytes_i[4][2*i +: 2]};
    end
  end

endmodule

// File: rtl/csi2_raw10_unpacker.sv
// Unpacks RAW10 long-packet payload beats (4 B/beat) into registered groups of four pixels.
module csi2_raw10_unpacker
  import csi2_pkg::*;
(
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic [3:0][7:0] image_data_i,
  input  logic [5:0]      image_data_type_i,
  input  logic [15:0]     word_count_i,
  input  logic            image_data_enable_i,
  output logic [3:0][9:0] pixel_o,
  output logic            pixel_enable_o,
  output logic            line_end_o,
  output logic            length_error_o
);

  logic [15:0]     consumed_q, consumed_d;
  logic [2:0]      count_q, count_d;
  logic [3:0][7:0] res_q, res_d;
  logic [3:0][9:0] pixel_q, pixel_d;
  logic            pixel_enable_q, line_end_q, length_error_q;
  logic            length_error_d;

  logic            qual, pkt_end, emit;
  logic [15:0]     remaining;
  logic [2:0]      valid;
  logic [3:0]      total, leftover;
  logic [7:0][7:0] comb;
  logic [3:0][9:0] group_pixels;

  always_comb begin
    qual      = image_data_enable_i && (image_data_type_i == DT_RAW10);
    remaining = (word_count_i > consumed_q) ? (word_count_i - consumed_q) : 16'd0;
    valid     = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
    total     = {1'b0, count_q} + {1'b0, valid};

    // Residue occupies the low lanes; new bytes append right behind it.
    comb = '0;
    for (int j = 0; j < 4; j++) begin
      comb[j] = res_q[j];
    end
    for (int i = 0; i < 4; i++) begin
      comb[count_q + 3'(i)] = image_data_i[i];
    end

    pkt_end  = qual && ((consumed_q + {13'd0, valid}) == word_count_i);
    emit     = qual && (total >= 4'(Raw10GroupBytes));
    leftover = emit ? (total - 4'(Raw10GroupBytes)) : total;

    consumed_d     = consumed_q;
    count_d        = count_q;
    res_d          = res_q;
    length_error_d = 1'b0;
    if (qual) begin
      consumed_d = pkt_end ? 16'd0 : (consumed_q + {13'd0, valid});
      count_d    = pkt_end ? 3'd0 : leftover[2:0];
      res_d      = emit ? {8'h00, comb[7], comb[6], comb[5]} : comb[3:0];
      length_error_d = pkt_end && (leftover != 4'd0) && (word_count_i != 16'd0);
    end

    pixel_d = emit ? group_pixels : pixel_q;
  end

  raw10_group_decode u_decode (
    .bytes_i (comb[4:0]),
    .pixel_o (group_pixels)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      consumed_q     <= '0;
      count_q        <= '0;
      res_q          <= '0;
      pixel_q        <= '0;
      pixel_enable_q <= 1'b0;
      line_end_q     <= 1'b0;
      length_error_q <= 1'b0;
    end else begin
      consumed_q     <= consumed_d;
      count_q        <= count_d;
      res_q          <= res_d;
      pixel_q        <= pixel_d;
      pixel_enable_q <= emit;
      line_end_q     <= emit && pkt_end;
      length_error_q <= length_error_d;
    end
  end

  assign pixel_o        = pixel_q;
  assign pixel_enable_o = pixel_enable_q;
  assign line_end_o     = line_end_q;
  assign length_error_o = length_error_q;

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Scoreboard bench: a byte-queue model predicts each output event when the beat is driven.
module tb_csi2_raw10_unpacker;
  import csi2_pkg::*;

  logic            clock_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic [3:0][7:0] image_data_i = '0;
  logic [5:0]      image_data_type_i = '0;
  logic [15:0]     word_count_i = '0;
  logic            image_data_enable_i = 1'b0;
  logic [3:0][9:0] pixel_o;
  logic            pixel_enable_o, line_end_o, length_error_o;

  csi2_raw10_unpacker dut (
    .clock_i             (clock_i),
    .reset_ni            (reset_ni),
    .image_data_i        (image_data_i),
    .image_data_type_i   (image_data_type_i),
    .word_count_i        (word_count_i),
    .image_data_enable_i (image_data_enable_i),
    .pixel_o             (pixel_o),
    .pixel_enable_o      (pixel_enable_o),
    .line_end_o          (line_end_o),
    .length_error_o      (length_error_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [3:0][9:0] pix;
    logic            en;
    logic            le;
    logic            err;
  } exp_t;

  exp_t            exp_q[$];
  logic [7:0]      mq[$];
  int              m_consumed = 0;
  int              n_cmp = 0, n_bad = 0, n_emit = 0, n_le = 0, n_err = 0;
  logic [3:0][9:0] last_pix = '0;

  // Monitor: every output event is popped against the scoreboard; idle cycles check hold.
  always @(negedge clock_i) begin
    if (reset_ni === 1'b1) begin
      if (pixel_enable_o || line_end_o || length_error_o) begin
        n_emit += int'(pixel_enable_o);
        n_le   += int'(line_end_o);
        n_err  += int'(length_error_o);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: en=%b le=%b err=%b pix=%h, required no event",
                   pixel_enable_o, line_end_o, length_error_o, pixel_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({pixel_enable_o, line_end_o, length_error_o} !== {e.en, e.le, e.err} ||
              (e.en && pixel_o !== e.pix)) begin
            n_bad++;
            $display("FAIL event: en=%b le=%b err=%b pix=%h, required en=%b le=%b err=%b pix=%h",
                     pixel_enable_o, line_end_o, length_error_o, pixel_o,
                     e.en, e.le, e.err, e.pix);
          end
          if (e.en) last_pix = e.pix;
        end
      end else begin
        n_cmp++;
        if (pixel_o !== last_pix) begin
          n_bad++;
          $display("FAIL pixel_hold: pix=%h, required %h", pixel_o, last_pix);
        end
      end
    end
  end

  // One beat, sampled at the next rising edge; the model predicts its output event.
  task automatic drive_beat(input logic [5:0] dt, input logic [15:0] wc,
                            input logic [3:0][7:0] d);
    exp_t       e;
    int         rem, nv;
    bit         last;
    logic [7:0] b[5];
    @(posedge clock_i);
    #1;
    image_data_i        = d;
    image_data_type_i   = dt;
    word_count_i        = wc;
    image_data_enable_i = 1'b1;
    if (dt == DT_RAW10) begin
      e   = '0;
      rem = (int'(wc) > m_consumed) ? int'(wc) - m_consumed : 0;
      nv  = (rem > 4) ? 4 : rem;
      for (int i = 0; i < nv; i++) mq.push_back(d[i]);
      m_consumed += nv;
      last = (m_consumed == int'(wc));
      if (mq.size() >= 5) begin
        for (int k = 0; k < 5; k++) b[k] = mq.pop_front();
        for (int i = 0; i < 4; i++) e.pix[i] = {b[i], 2'((b[4] >> (2 * i)) & 8'h03)};
        e.en = 1'b1;
        e.le = last;
      end
      if (last) begin
        e.err = (mq.size() != 0) && (wc != 16'd0);
        mq.delete();
        m_consumed = 0;
      end
      if (e.en || e.err) exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_i);
      #1;
      image_data_enable_i = 1'b0;
      image_data_i        = 32'($urandom);
    end
  endtask

  task automatic send_packet(input logic [5:0] dt, input int wc, input int first);
    int nb;
    logic [3:0][7:0] d;
    nb = (wc == 0) ? 1 : (wc + 3) / 4;
    for (int bt = 0; bt < nb; bt++) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = bt * 4 + i;
        d[i] = (k < wc) ? 8'(first + k) : 8'($urandom);
      end
      drive_beat(dt, 16'(wc), d);
    end
  endtask

  task automatic drain(input string name);
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_delta(input string name, input int got, input int want);
    // Per-test tallies of emit/line_end/error pulses against the planned packet shape.
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: count=%0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    @(negedge clock_i);
    n_cmp++;
    if (pixel_o !== '0 || pixel_enable_o !== 1'b0 || line_end_o !== 1'b0 ||
        length_error_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: pix=%h en=%b le=%b err=%b, required all zero",
               name, pixel_o, pixel_enable_o, line_end_o, length_error_o);
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(posedge clock_i);
    check_zero_outputs("reset_state");
    @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
    idle(2);
  endtask

  task automatic test_single_group();
    int e0, l0, r0;
    e0 = n_emit; l0 = n_le; r0 = n_err;
    drive_beat(DT_RAW10, 16'd5, {8'hAA, 8'h55, 8'h00, 8'hFF});
    drive_beat(DT_RAW10, 16'd5, {8'hEE, 8'hEE, 8'hEE, 8'h93});
    idle(1);
    @(negedge clock_i);
    n_cmp++;
    if (pixel_enable_o !== 1'b1 || line_end_o !== 1'b1 || length_error_o !== 1'b0 ||
        pixel_o[0] !== 10'h3FF || pixel_o[1] !== 10'h000 ||
        pixel_o[2] !== 10'h155 || pixel_o[3] !== 10'h2AA) begin
      n_bad++;
      $display("FAIL single_group: en=%b le=%b err=%b pix=%h, required 1 1 0 2aa/155/000/3ff",
               pixel_enable_o, line_end_o, length_error_o, pixel_o);
    end
    drain("single_group");
    check_delta("single_emits", n_emit - e0, 1);
    check_delta("single_line_end", n_le - l0, 1);
    check_delta("single_errors", n_err - r0, 0);
  endtask

  task automatic test_line20();
    int e0, l0, r0;
    e0 = n_emit; l0 = n_le; r0 = n_err;
    send_packet(DT_RAW10, 20, 8'h10);
    drain("line20");
    check_delta("line20_emits", n_emit - e0, 4);
    check_delta("line20_line_end", n_le - l0, 1);
    check_delta("line20_errors", n_err - r0, 0);
  endtask

  task automatic test_bad_length();
    int e0, r0;
    e0 = n_emit; r0 = n_err;
    send_packet(DT_RAW10, 7, 8'h40);
    drain("bad_length");
    check_delta("bad_len_emits", n_emit - e0, 1);
    check_delta("bad_len_errors", n_err - r0, 1);
    e0 = n_emit; r0 = n_err;
    send_packet(DT_RAW10, 5, 8'hC0);
    drain("after_bad_length");
    check_delta("clean_emits", n_emit - e0, 1);
    check_delta("clean_errors", n_err - r0, 0);
  endtask

  task automatic test_other_dt();
    int e0, r0;
    e0 = n_emit; r0 = n_err;
    drive_beat(DT_RAW10, 16'd10, {8'h83, 8'h82, 8'h81, 8'h80});
    send_packet(6'h18, 8, 8'h20);
    idle(1);
    drive_beat(DT_RAW10, 16'd10, {8'h87, 8'h86, 8'h85, 8'h84});
    drive_beat(DT_RAW10, 16'd10, {8'h5A, 8'hA5, 8'h89, 8'h88});
    drain("other_dt");
    check_delta("other_dt_emits", n_emit - e0, 2);
    check_delta("other_dt_errors", n_err - r0, 0);
  endtask

  task automatic test_partial_last();
    int e0, l0;
    e0 = n_emit; l0 = n_le;
    send_packet(DT_RAW10, 10, 8'h60);
    drain("partial_last");
    check_delta("partial_emits", n_emit - e0, 2);
    check_delta("partial_line_end", n_le - l0, 1);
  endtask

  task automatic test_mid_reset();
    int e0;
    drive_beat(DT_RAW10, 16'd10, {8'hF3, 8'hF2, 8'hF1, 8'hF0});
    @(posedge clock_i);
    #1;
    image_data_enable_i = 1'b0;
    reset_ni = 1'b0;
    mq.delete();
    m_consumed = 0;
    check_zero_outputs("mid_reset");
    @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
    last_pix = '0;
    idle(1);
    e0 = n_emit;
    send_packet(DT_RAW10, 5, 8'h30);
    drain("after_reset");
    check_delta("after_reset_emits", n_emit - e0, 1);
  endtask

  task automatic test_back_to_back();
    int lens[8] = '{15, 12, 0, 13, 20, 5, 9, 40};
    for (int p = 0; p < 8; p++) send_packet(DT_RAW10, lens[p], int'($urandom_range(0, 255)));
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_line20();
    test_bad_length();
    test_other_dt();
    test_partial_last();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
